// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULTU/DIVU sequencer for HI/LO; MULDIV_FAST_MULT_EN selects a single-cycle multiply
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             read_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         state;
    logic [CW-1:0]      count;
    logic               op_r;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   div_diff;
    logic               last;

    // acc holds {hi_part, multiplier} for MULTU and {remainder, quotient} for DIVU
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = {1'b0, rem_sh} - {2'b00, opnd};
        step_acc = {mul_sum, acc[WIDTH-1:1]};
        if (op_r) begin
            if (div_diff[WIDTH+1])
                step_acc = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                step_acc = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
`ifdef MULDIV_FAST_MULT_EN
        // the product was already captured into acc on the accept edge
        last   = op_r ? (count == CW'(WIDTH - 1)) : 1'b1;
        result = op_r ? step_acc : acc;
`else
        last   = (count == CW'(WIDTH - 1));
        result = step_acc;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
            op_r  <= 1'b0;
            opnd  <= '0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    op_r  <= op;
                    opnd  <= op ? b : a;
                    acc   <= op ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
`ifdef MULDIV_FAST_MULT_EN
                    if (!op)
                        acc <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif
                    count <= '0;
                    state <= S_RUN;
                end
            end else begin
                acc   <= step_acc;
                count <= count + 1'b1;
                if (last) begin
                    hi    <= result[2*WIDTH-1:WIDTH];
                    lo    <= result[WIDTH-1:0];
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
            end
        end
    end

    assign busy  = (state == S_RUN);
    assign stall = busy & (start | read_req);

endmodule
